// File: rtl/ha_adder_pkg.sv
// Shared types and helpers for the serial digit adder (tt_um_ha_serial_adder).
// The optional subtract feature is enabled by defining HA_SUB_EN.
package ha_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic c;
      logic s;
   } ha_t;

   function automatic int ndig(input int width, input int digit);
      return width / digit;
   endfunction

   // Digit counter width; a single-digit operation still needs one bit.
   function automatic int cnt_w(input int width, input int digit);
      int n;
      n = width / digit;
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic ha_t half_add(input logic x, input logic y);
      ha_t r;
      r.s = x ^ y;
      r.c = x & y;
      return r;
   endfunction

endpackage

// File: rtl/ha_adder_if.sv
// Operand/result handshake bundle for tt_um_ha_serial_adder.
// The sub signal exists only when HA_SUB_EN is defined.
interface ha_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef HA_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
`ifdef HA_SUB_EN
      output sub,
`endif
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
`ifdef HA_SUB_EN
      input  sub,
`endif
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/ha_digit_add.sv
// DIGIT-bit ripple adder; each full adder is a pair of half-adder cells
// plus an OR on their carries.
module ha_digit_add
   import ha_adder_pkg::*;
#(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);
   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      ha_t h1;
      ha_t h2;
      assign h1       = half_add(a[i], b[i]);
      assign h2       = half_add(h1.s, c[i]);
      assign s[i]     = h2.s;
      assign c[i+1]   = h1.c | h2.c;
   end

   assign co = c[DIGIT];
endmodule

// File: rtl/tt_um_ha_serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed DIGIT bits per clock, LSB first.
// Define HA_SUB_EN to add the sub port (a - b via inverted b and forced carry-in).
module tt_um_ha_serial_adder
   import ha_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     ena,
   ha_adder_if.slave bus
);
   localparam int NDIG  = ndig(WIDTH, DIGIT);
   localparam int CNT_W = cnt_w(WIDTH, DIGIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("tt_um_ha_serial_adder: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
             WIDTH, DIGIT);
   end

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             step;
   logic             last;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] b_cap;
   logic             c_cap;
   logic             carry;
   logic             cout_q;
   logic [CNT_W-1:0] cnt;

   logic [DIGIT-1:0] d_s;
   logic             d_co;

`ifdef HA_SUB_EN
   assign b_cap = bus.sub ? ~bus.b : bus.b;
   assign c_cap = bus.sub | bus.cin;
`else
   assign b_cap = bus.b;
   assign c_cap = bus.cin;
`endif

   ha_digit_add #(.DIGIT(DIGIT)) u_digit (
      .a  (a_sh[DIGIT-1:0]),
      .b  (b_sh[DIGIT-1:0]),
      .ci (carry),
      .s  (d_s),
      .co (d_co)
   );

   // New digit enters at the top, so after NDIG steps the LSB digit sits at bit 0.
   assign acc_nxt = (acc >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));
   assign last    = (cnt == LAST);

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the datapath is reset too, so an aborted operation leaves sum/cout at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (ena) begin
         if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= b_cap;
            carry <= c_cap;
            acc   <= '0;
            cnt   <= '0;
         end else if (step) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            carry <= d_co;
            acc   <= acc_nxt;
            cnt   <= cnt + 1'b1;
            // Visible result only changes on the RUN->DONE step.
            if (last) begin
               sum_q  <= acc_nxt;
               cout_q <= d_co;
            end
         end
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_tt_um_ha_serial_adder.sv
// Self-checking bench for tt_um_ha_serial_adder: cycle model compared every cycle,
// directed literal cases, random operations, and 16-bit variants.
module tb_tt_um_ha_serial_adder;
   localparam int W = 8;
   localparam int D = 2;
   localparam int N = W / D;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic ena   = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_err    = 0;
   bit   chk_en   = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ha_adder_if #(.WIDTH(W))  bus ();
   ha_adder_if #(.WIDTH(16)) bus_w4 ();
   ha_adder_if #(.WIDTH(16)) bus_w16 ();

   tt_um_ha_serial_adder #(.WIDTH(W),  .DIGIT(D))  dut     (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus));
   tt_um_ha_serial_adder #(.WIDTH(16), .DIGIT(4))  dut_w4  (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus_w4));
   tt_um_ha_serial_adder #(.WIDTH(16), .DIGIT(16)) dut_w16 (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus_w16));

   logic sub_in;
`ifdef HA_SUB_EN
   assign sub_in = bus.sub;
`else
   assign sub_in = 1'b0;
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
      logic [W-1:0] b_eff;
      logic         c_eff;
      b_eff = sub ? ~b : b;
      c_eff = sub ? 1'b1 : cin;
      return {1'b0, a} + {1'b0, b_eff} + (W+1)'(c_eff);
   endfunction

   function automatic logic [16:0] golden16(input logic [15:0] a, input logic [15:0] b, input logic cin);
      return {1'b0, a} + {1'b0, b} + 17'(cin);
   endfunction

   // Reference: an accepted operation produces a+b+cin after N enabled cycles.
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic         m_cout = 1'b0;
   logic [W-1:0] m_sum  = '0;
   logic [W:0]   m_pend = '0;
   int           m_left = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_cout <= 1'b0;
         m_sum  <= '0;
         m_left <= 0;
      end else if (ena) begin
         if (!m_busy && bus.start) begin
            m_pend <= golden(bus.a, bus.b, bus.cin, sub_in);
            m_left <= N;
            m_busy <= 1'b1;
            m_done <= 1'b0;
         end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy           <= 1'b0;
               m_done           <= 1'b1;
               {m_cout, m_sum}  <= m_pend;
            end
         end else begin
            m_done <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_busy", bus.busy, m_busy);
         check("model_done", bus.done, m_done);
         check("model_sum",  bus.sum,  m_sum);
         check("model_cout", bus.cout, m_cout);
      end
   end

   // Called at a falling edge; returns at the next falling edge after start was sampled.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
`ifdef HA_SUB_EN
      bus.sub   = sub;
`else
      if (sub) $display("note: sub request ignored in add-only build");
`endif
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (!bus.done && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("done_seen", bus.done, 1'b1);
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin);
      int l4;
      int l16;
      logic [16:0] g;
      g = golden16(a, b, cin);
      l4 = 0;
      l16 = 0;
      bus_w4.a  = a;  bus_w4.b  = b;  bus_w4.cin  = cin;  bus_w4.start  = 1'b1;
      bus_w16.a = a;  bus_w16.b = b;  bus_w16.cin = cin;  bus_w16.start = 1'b1;
      @(negedge clk);
      bus_w4.start  = 1'b0;
      bus_w16.start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus_w4.done && l4 == 0) begin
            l4 = k;
            check("w16d4_result", {bus_w4.cout, bus_w4.sum}, g);
         end
         if (bus_w16.done && l16 == 0) begin
            l16 = k;
            check("w16d16_result", {bus_w16.cout, bus_w16.sum}, g);
         end
      end
      check("w16d4_latency",  l4,  4);
      check("w16d16_latency", l16, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int t1;
      int t2;
      int k;
      bit seen;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      logic [W:0]   g;

      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
`ifdef HA_SUB_EN
      bus.sub = 1'b0; bus_w4.sub = 1'b0; bus_w16.sub = 1'b0;
`endif
      bus_w4.start = 1'b0;  bus_w4.a = '0;  bus_w4.b = '0;  bus_w4.cin = 1'b0;
      bus_w16.start = 1'b0; bus_w16.a = '0; bus_w16.b = '0; bus_w16.cin = 1'b0;

      // 1. Reset held, then released between clock edges.
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_sum",  bus.sum,  8'h00);
      check("rst_cout", bus.cout, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_sum",  bus.sum,  8'h00);
      check("post_rst_done", bus.done, 1'b0);

      // 2. Full carry ripple.
      start_op(8'hFF, 8'h01, 1'b0, 1'b0);
      check("t2_busy", bus.busy, 1'b1);
      wait_done(0, lat);
      check("t2_latency", lat, 4);
      check("t2_sum",  bus.sum,  8'h00);
      check("t2_cout", bus.cout, 1'b1);
      @(negedge clk);

      // 3. Carry-in used; a start while busy is ignored.
      start_op(8'h5A, 8'h33, 1'b1, 1'b0);
      bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(1, lat);
      check("t3_latency", lat, 4);
      check("t3_sum",  bus.sum,  8'h8E);
      check("t3_cout", bus.cout, 1'b0);
      @(negedge clk);
      check("t3_no_extra_busy", bus.busy, 1'b0);

      // 4. Back-to-back: start held high through the DONE cycle.
      bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.done && k < 20);
      t1 = cyc;
      check("t4_first_sum", {bus.cout, bus.sum}, 9'h046);
      bus.a = 8'hC8; bus.b = 8'h64; bus.cin = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("t4_second_busy", bus.busy, 1'b1);
      k = 0;
      while (!bus.done && k < 20) begin @(negedge clk); k++; end
      t2 = cyc;
      check("t4_done_spacing", t2 - t1, 5);
      check("t4_second_sum", {bus.cout, bus.sum}, 9'h12D);
      @(negedge clk);

      // 5a. Three stalled cycles mid-RUN, then a stall holding done.
      start_op(8'h77, 8'h99, 1'b0, 1'b0);
      ena = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_stall_busy", bus.busy, 1'b1);
      ena = 1'b1;
      wait_done(3, lat);
      check("t5_latency", lat, 7);
      check("t5_sum", {bus.cout, bus.sum}, 9'h110);
      ena = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("t5_done_held", bus.done, 1'b1);
      end
      ena = 1'b1;
      @(negedge clk);
      check("t5_done_drop", bus.done, 1'b0);

      // 5b. Reset during RUN aborts with no done.
      start_op(8'h0F, 8'h0F, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_abort_sum",  bus.sum,  8'h00);
      check("t5_abort_cout", bus.cout, 1'b0);
      check("t5_abort_busy", bus.busy, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check("t5_no_done", seen, 1'b0);

`ifdef HA_SUB_EN
      // 6. Subtraction.
      start_op(8'h10, 8'h01, 1'b0, 1'b1);
      wait_done(0, lat);
      check("t6_sub_a", {bus.cout, bus.sum}, 9'h10F);
      @(negedge clk);
      start_op(8'h01, 8'h02, 1'b0, 1'b1);
      wait_done(0, lat);
      check("t6_sub_b", {bus.cout, bus.sum}, 9'h0FF);
      @(negedge clk);
      bus.sub = 1'b0;
`endif

      // Random operations with random clock-enable stalls.
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
`ifdef HA_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         g = golden(ra, rb, rc, rs);
         start_op(ra, rb, rc, rs);
         k = 0;
         while (!bus.done && k < 80) begin
            ena = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            k++;
         end
         ena = 1'b1;
         check("rand_result", {bus.cout, bus.sum}, g);
         @(negedge clk);
      end

      // Wider variants, including single-cycle RUN.
      run16(16'hFFFF, 16'h0001, 1'b0);
      run16(16'h5A5A, 16'h3333, 1'b1);
      for (int i = 0; i < 6; i++) begin
         run16(16'($urandom), 16'($urandom), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
